// File: rtl/wallace_tree_multiplier.sv
// Unsigned 3x3 Wallace-tree multiplier with ripple-carry final adder and registered outputs.
// Define WALLACE_PIPE_EN to register the two reduced rows ahead of the final adder (latency 2).

module wallace_ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module wallace_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module wallace_tree_multiplier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [5:0] PRODUCT,
  output logic       cout
);

  // w_pp[i][j] carries weight 2^(i+j)
  logic [2:0][2:0] w_pp;

  for (genvar gi = 0; gi < 3; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_pp_col
      assign w_pp[gi][gj] = A[gj] & B[gi];
    end
  end

  logic w_s1_1, w_c1_1;
  logic w_s1_2, w_c1_2;
  logic w_s1_3, w_c1_3;

  wallace_ha u_s1_col1 (
    .i_a (w_pp[0][1]),
    .i_b (w_pp[1][0]),
    .o_s (w_s1_1),
    .o_c (w_c1_1)
  );

  wallace_fa u_s1_col2 (
    .i_a (w_pp[0][2]),
    .i_b (w_pp[1][1]),
    .i_c (w_pp[2][0]),
    .o_s (w_s1_2),
    .o_c (w_c1_2)
  );

  wallace_ha u_s1_col3 (
    .i_a (w_pp[1][2]),
    .i_b (w_pp[2][1]),
    .o_s (w_s1_3),
    .o_c (w_c1_3)
  );

  // After stage 1 every column already holds at most two bits, so stage 2 only
  // arranges them into the two rows fed to the final adder.
  logic [5:0] w_row_a;
  logic [5:0] w_row_b;

  assign w_row_a = {1'b0, w_pp[2][2], w_s1_3, w_s1_2, w_s1_1, w_pp[0][0]};
  assign w_row_b = {1'b0, w_c1_3, w_c1_2, w_c1_1, 2'b00};

  logic [5:0] w_add_a;
  logic [5:0] w_add_b;

`ifdef WALLACE_PIPE_EN
  logic [5:0] r_row_a;
  logic [5:0] r_row_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_a <= '0;
      r_row_b <= '0;
    end else begin
      r_row_a <= w_row_a;
      r_row_b <= w_row_b;
    end
  end

  assign w_add_a = r_row_a;
  assign w_add_b = r_row_b;
`else
  assign w_add_a = w_row_a;
  assign w_add_b = w_row_b;
`endif

  logic [6:0] w_carry;
  logic [5:0] w_sum;

  assign w_carry[0] = 1'b0;

  for (genvar gk = 0; gk < 6; gk++) begin : g_ripple
    wallace_fa u_fa (
      .i_a (w_add_a[gk]),
      .i_b (w_add_b[gk]),
      .i_c (w_carry[gk]),
      .o_s (w_sum[gk]),
      .o_c (w_carry[gk+1])
    );
  end

  logic [5:0] r_product;
  logic       r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_product <= w_sum;
      r_cout    <= w_carry[6];
    end
  end

  assign PRODUCT = r_product;
  assign cout    = r_cout;

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Scoreboard bench for wallace_tree_multiplier: expected products queued at sampling, checked by a monitor.
module tb_wallace_tree_multiplier;

`ifdef WALLACE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] A = '0;
  logic [2:0] B = '0;
  logic [5:0] PRODUCT;
  logic       cout;

  wallace_tree_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .PRODUCT (PRODUCT),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] p;
  } exp_t;

  exp_t q[$];
  int   cnt   = 0;
  bit   armed = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference: every edge out of reset captures one operand pair whose product is A*B.
  always @(posedge clk) begin
    if (armed && rst_n) begin
      exp_t e;
      e.a = A;
      e.b = B;
      e.p = 6'(int'(A) * int'(B));
      q.push_back(e);
      cnt++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (!rst_n || cnt < LAT) begin
        total++;
        if (PRODUCT !== 6'd0 || cout !== 1'b0) begin
          bad++;
          $display("FAIL idle_zero: got PRODUCT=%0d cout=%0d, want 0/0 (rst_n=%0b cnt=%0d)",
                   PRODUCT, cout, rst_n, cnt);
        end
      end else if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got PRODUCT=%0d with no expected entry", PRODUCT);
      end else begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (PRODUCT !== e.p || cout !== 1'b0) begin
          bad++;
          $display("FAIL product %0d*%0d: got PRODUCT=%0d cout=%0d, want %0d/0",
                   e.a, e.b, PRODUCT, cout, e.p);
        end
      end
    end
  end

  task automatic apply(input logic [2:0] a, input logic [2:0] b);
    @(posedge clk);
    #2;
    A = a;
    B = b;
  endtask

  task automatic pull_reset(input logic [2:0] a, input logic [2:0] b, input string tag);
    @(posedge clk);
    #2;
    A = a;
    B = b;
    rst_n = 1'b0;
    armed = 1'b1;
    q.delete();
    cnt = 0;
    #1;
    total++;
    if (PRODUCT !== 6'd0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL %s: got PRODUCT=%0d cout=%0d right after rst_n fell, want 0/0",
               tag, PRODUCT, cout);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [2:0] dir_a [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7, 3'd5, 3'd6, 3'd7};
  logic [2:0] dir_b [9] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7, 3'd2, 3'd3, 3'd0};

  initial begin
    // Fill the datapath with a nonzero result so the reset check is meaningful.
    A = 3'd3;
    B = 3'd3;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (PRODUCT !== 6'd9) begin
      bad++;
      $display("FAIL pre_reset 3*3: got PRODUCT=%0d, want 9", PRODUCT);
    end

    pull_reset(3'd7, 3'd7, "async_reset");
    repeat (2) @(posedge clk);
    release_reset();

    for (int i = 0; i < 9; i++) apply(dir_a[i], dir_b[i]);

    for (int i = 0; i < 64; i++) apply(3'(i / 8), 3'(i % 8));

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        apply(3'(1 << i), 3'(1 << j));

    for (int i = 0; i < 40; i++) apply(3'($urandom_range(7)), 3'($urandom_range(7)));

    pull_reset(3'd6, 3'd5, "midstream_reset");
    @(posedge clk);
    release_reset();

    for (int i = 0; i < 40; i++) apply(3'($urandom_range(7)), 3'($urandom_range(7)));

    repeat (LAT + 2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
